arbiter8way: RTL and testbench

Round-robin arbiter that shares a single 16-bit datapath (an 8-way 16-bit mux feeding one consumer, with the matching 8-way demux routing the return strobe) among eight requesters. Registered `sel` drives the mux/demux select lines directly; registered one-hot `grant` tells each requester it owns the path. Ownership lasts until the owner signals its final beat, drops its request, or hits a hold limit. Rotating priority guarantees every requester is served within 7 handovers.

---
 rtl/arbiter8way_pkg.sv | 11 +
 rtl/rr_pick8.sv | 20 ++
 rtl/arbiter8way.sv | 94 +++++++++
 tb/tb_arbiter8way.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter8way_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin datapath arbiter.
package arbiter8way_pkg;
    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 8.
module rr_pick8
    import arbiter8way_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = ptr;
        // Descending scan so the nearest-to-ptr requester is the final assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
        end
    end

endmodule

// File: rtl/arbiter8way.sv
// Round-robin owner arbiter for a shared 16-bit path; registered one-hot grant and mux select.
module arbiter8way
    import arbiter8way_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt, sel_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [SEL_W-1:0]  pick_ptr, pick_idx, sel_inc;
    logic              pick_found, rel;

    assign sel_inc = sel + SEL_W'(1);
    assign rel     = !req[sel] || last[sel] || (hold == HOLD_W'(MAX_HOLD));

    // While owning, the picker already sees the post-release priority so a
    // handover costs no bubble; the outgoing owner ends up lowest priority.
    assign pick_ptr = (state == ST_OWN) ? sel_inc : ptr;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        hold_nxt  = hold;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_OWN;
                    grant_nxt = N_REQ'(1) << pick_idx;
                    sel_nxt   = pick_idx;
                    hold_nxt  = HOLD_W'(1);
                end
            end
            ST_OWN: begin
                if (!rel) begin
                    hold_nxt = hold + HOLD_W'(1);
                end else begin
                    ptr_nxt = sel_inc;
                    if (pick_found) begin
                        grant_nxt = N_REQ'(1) << pick_idx;
                        sel_nxt   = pick_idx;
                        hold_nxt  = HOLD_W'(1);
                    end else begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                        hold_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sel   <= '0;
            hold  <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            hold  <= hold_nxt;
            grant <= grant_nxt;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_arbiter8way.sv
// Directed scenario bench for arbiter8way with hand-computed expectations.
module tb_arbiter8way;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] last = '0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    int checks = 0;
    int errors = 0;

    arbiter8way #(.MAX_HOLD(16)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .last(last),
        .grant(grant), .sel(sel), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        last = '0;
        #12;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = '0;
        #1;
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state grant=%h sel=%0d busy=%b want 00/0/0", grant, sel, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_cyc%0d grant=%h sel=%0d busy=%b want 00/0/0", i, grant, sel, busy);
            end
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        req = 8'h08;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant !== 8'h08 || sel !== 3'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_cyc%0d grant=%h sel=%0d busy=%b want 08/3/1", i, grant, sel, busy);
            end
        end
        last = 8'h08;
        req = 8'h00;
        step();
        checks++;
        if (grant !== 8'h00 || sel !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end grant=%h sel=%0d busy=%b want 00/3/0", grant, sel, busy);
        end
        // ptr is now 4: of {0,4} requester 4 must win
        last = 8'h00;
        req = 8'h11;
        step();
        checks++;
        if (grant !== 8'h10 || sel !== 3'd4) begin
            errors++;
            $display("FAIL burst_ptr grant=%h sel=%0d want 10/4", grant, sel);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        do_reset();
        req = 8'hFF;
        last = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_g = 8'h01 << (i % 8);
            checks++;
            if (grant !== exp_g || sel !== 3'(i % 8) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation_cyc%0d grant=%h sel=%0d busy=%b want %h/%0d/1", i, grant, sel, busy, exp_g, i % 8);
            end
        end
        req = '0;
        last = '0;
        step();
    endtask

    task automatic test_hold_limit();
        logic [7:0] exp_g;
        do_reset();
        req = 8'h21;
        for (int c = 0; c < 40; c++) begin
            step();
            exp_g = ((c / 16) % 2 == 0) ? 8'h01 : 8'h20;
            checks++;
            if (grant !== exp_g || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cyc%0d grant=%h busy=%b want %h/1", c, grant, busy, exp_g);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_abandon_sole();
        do_reset();
        req = 8'h40;
        step();
        step();
        checks++;
        if (grant !== 8'h40 || sel !== 3'd6) begin
            errors++;
            $display("FAIL abandon_own grant=%h sel=%0d want 40/6", grant, sel);
        end
        req = 8'h00;
        step();
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd6) begin
            errors++;
            $display("FAIL abandon_drop grant=%h busy=%b sel=%0d want 00/0/6", grant, busy, sel);
        end
        req = 8'h40;
        last = 8'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant !== 8'h40 || sel !== 3'd6 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sole_cyc%0d grant=%h sel=%0d busy=%b want 40/6/1", i, grant, sel, busy);
            end
        end
        req = '0;
        last = '0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        step();
        checks++;
        if (grant !== 8'h10) begin
            errors++;
            $display("FAIL areset_pre grant=%h want 10", grant);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
            errors++;
            $display("FAIL areset_drop grant=%h busy=%b sel=%0d want 00/0/0", grant, busy, sel);
        end
        req = 8'h11;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_regrant grant=%h sel=%0d busy=%b want 01/0/1", grant, sel, busy);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_rotation();
        test_hold_limit();
        test_abandon_sole();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
